// File: rtl/l1_store_buffer_pkg.sv
// Shared L1/L2 definitions used by the store buffer: sizes, unit/op enums,
// L2 request/response packets and the store-buffer entry types.
package l1_store_buffer_pkg;

    localparam int STRANDS_PER_CORE   = 4;
    localparam int STRAND_INDEX_WIDTH = 2;
    localparam int CACHE_LINE_BITS    = 512;
    localparam int CACHE_LINE_BYTES   = CACHE_LINE_BITS / 8;
    localparam int L1_ADDR_WIDTH      = 26;
    localparam int CORE_INDEX_WIDTH   = 4;

    typedef enum logic [1:0] {
        UNIT_ICACHE,
        UNIT_DCACHE,
        UNIT_STBUF
    } unit_id_t;

    typedef enum logic [2:0] {
        L2REQ_LOAD,
        L2REQ_STORE,
        L2REQ_STORE_SYNC,
        L2REQ_FLUSH
    } l2req_op_t;

    typedef enum logic [1:0] {
        L2RSP_LOAD_ACK,
        L2RSP_STORE_ACK
    } l2rsp_op_t;

    typedef enum logic [1:0] {
        SB_EMPTY,
        SB_PENDING,
        SB_ISSUED
    } sb_state_t;

    typedef struct packed {
        logic                          valid;
        l2req_op_t                     op;
        unit_id_t                      unit;
        logic [STRAND_INDEX_WIDTH-1:0] strand;
        logic [CORE_INDEX_WIDTH-1:0]   core;
        logic [L1_ADDR_WIDTH-1:0]      address;
        logic [CACHE_LINE_BITS-1:0]    data;
        logic [CACHE_LINE_BYTES-1:0]   mask;
    } l2req_packet_t;

    typedef struct packed {
        logic                          valid;
        logic                          status;
        l2rsp_op_t                     op;
        unit_id_t                      unit;
        logic [CORE_INDEX_WIDTH-1:0]   core;
        logic [STRAND_INDEX_WIDTH-1:0] strand;
    } l2rsp_packet_t;

    typedef struct packed {
        logic                        sync;
        logic [L1_ADDR_WIDTH-1:0]    addr;
        logic [CACHE_LINE_BITS-1:0]  data;
        logic [CACHE_LINE_BYTES-1:0] mask;
    } sb_entry_t;

endpackage

// File: rtl/l1_store_buffer_arbiter_rr.sv
// Round-robin arbiter: priority starts at the slot after the last update.
// The grant is held while unaccepted so a requester never loses a half-offered slot.
module arbiter_rr #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_request,
    input  logic               i_update_en,
    output logic [NUM_REQ-1:0] o_grant_oh,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_valid
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W-1:0] r_ptr;
    logic             r_lock_valid;
    logic [IDX_W-1:0] r_lock_idx;

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_free_valid;
    logic [IDX_W-1:0] w_sel_idx;
    logic [IDX_W-1:0] w_next_ptr;

    // Walk from the lowest priority upward so the highest-priority hit wins.
    always_comb begin
        w_sum        = '0;
        w_cand       = '0;
        w_free_valid = 1'b0;
        w_free_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_sum >= NUM_REQ_W) w_sum = w_sum - NUM_REQ_W;
            w_cand = w_sum[IDX_W-1:0];
            if (i_request[w_cand]) begin
                w_free_valid = 1'b1;
                w_free_idx   = w_cand;
            end
        end
    end

    assign w_sel_idx     = (r_lock_valid && i_request[r_lock_idx]) ? r_lock_idx : w_free_idx;
    assign w_next_ptr    = (w_sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_sel_idx + IDX_W'(1);
    assign o_grant_valid = w_free_valid;
    assign o_grant_idx   = w_sel_idx;
    assign o_grant_oh    = w_free_valid ? (NUM_REQ'(1) << w_sel_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr        <= '0;
            r_lock_valid <= 1'b0;
            r_lock_idx   <= '0;
        end else if (w_free_valid && i_update_en) begin
            r_ptr        <= w_next_ptr;
            r_lock_valid <= 1'b0;
        end else begin
            r_lock_valid <= w_free_valid;
            r_lock_idx   <= w_sel_idx;
        end
    end

endmodule

// File: rtl/l1_store_buffer.sv
// One-store-per-strand buffer beside the L1 D$: accepts stores, forwards them to
// same-strand loads, issues them round-robin to L2 and retires them on store ack.
module l1_store_buffer
    import l1_store_buffer_pkg::*;
#(
    parameter int CORE_ID = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          store_en,
    input  logic                          synchronized_i,
    input  logic [STRAND_INDEX_WIDTH-1:0] store_strand,
    input  logic [L1_ADDR_WIDTH-1:0]      request_addr,
    input  logic [CACHE_LINE_BITS-1:0]    data_to_dcache,
    input  logic [CACHE_LINE_BYTES-1:0]   dcache_store_mask,
    input  logic                          load_en,
    output logic                          rollback_o,
    output logic [CACHE_LINE_BITS-1:0]    data_o,
    output logic [CACHE_LINE_BYTES-1:0]   mask_o,
    output logic [STRANDS_PER_CORE-1:0]   resume_strands_o,
    output logic                          sync_result_o,
    input  logic                          l2req_ready,
    output l2req_packet_t                 l2req_packet,
    input  l2rsp_packet_t                 l2rsp_packet
);

    localparam logic [CORE_INDEX_WIDTH-1:0] CORE_IDX = CORE_INDEX_WIDTH'(CORE_ID);

    sb_state_t r_state      [STRANDS_PER_CORE];
    sb_state_t w_state_next [STRANDS_PER_CORE];
    sb_entry_t r_entry      [STRANDS_PER_CORE];

    logic                          w_ack;
    logic                          w_ack_hit;
    logic                          w_store_ok;
    logic                          w_load_hit;
    logic                          w_issue;
    logic [STRANDS_PER_CORE-1:0]   w_pending;
    logic [STRANDS_PER_CORE-1:0]   w_grant_oh;
    logic [STRAND_INDEX_WIDTH-1:0] w_grant_idx;
    logic                          w_grant_valid;

    assign w_ack = l2rsp_packet.valid && (l2rsp_packet.op == L2RSP_STORE_ACK)
                && (l2rsp_packet.unit == UNIT_STBUF) && (l2rsp_packet.core == CORE_IDX);
    assign w_ack_hit = w_ack && (r_state[l2rsp_packet.strand] == SB_ISSUED);

    // An entry retiring this cycle can take the strand's next store directly.
    assign w_store_ok = store_en && ((r_state[store_strand] == SB_EMPTY)
                     || (w_ack_hit && (l2rsp_packet.strand == store_strand)));

    assign w_load_hit = load_en && (r_state[store_strand] != SB_EMPTY)
                     && (r_entry[store_strand].addr == request_addr);

    assign w_issue = w_grant_valid && l2req_ready;

    always_comb begin
        for (int i = 0; i < STRANDS_PER_CORE; i++) begin
            w_pending[i] = (r_state[i] == SB_PENDING);
        end
    end

    arbiter_rr #(.NUM_REQ(STRANDS_PER_CORE)) u_arbiter (
        .clk           (clk),
        .reset         (reset),
        .i_request     (w_pending),
        .i_update_en   (l2req_ready),
        .o_grant_oh    (w_grant_oh),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    always_comb begin
        for (int i = 0; i < STRANDS_PER_CORE; i++) begin
            w_state_next[i] = r_state[i];
            if (w_store_ok && (store_strand == STRAND_INDEX_WIDTH'(i)))
                w_state_next[i] = SB_PENDING;
            else if (w_ack_hit && (l2rsp_packet.strand == STRAND_INDEX_WIDTH'(i)))
                w_state_next[i] = SB_EMPTY;
            else if (w_issue && w_grant_oh[i])
                w_state_next[i] = SB_ISSUED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STRANDS_PER_CORE; i++) begin
                r_state[i] <= SB_EMPTY;
                r_entry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STRANDS_PER_CORE; i++) begin
                r_state[i] <= w_state_next[i];
                if (w_store_ok && (store_strand == STRAND_INDEX_WIDTH'(i)))
                    r_entry[i] <= '{sync: synchronized_i, addr: request_addr,
                                    data: data_to_dcache, mask: dcache_store_mask};
            end
        end
    end

    always_comb begin
        l2req_packet = '0;
        if (w_grant_valid) begin
            l2req_packet.valid   = 1'b1;
            l2req_packet.op      = r_entry[w_grant_idx].sync ? L2REQ_STORE_SYNC : L2REQ_STORE;
            l2req_packet.unit    = UNIT_STBUF;
            l2req_packet.strand  = w_grant_idx;
            l2req_packet.core    = CORE_IDX;
            l2req_packet.address = r_entry[w_grant_idx].addr;
            l2req_packet.data    = r_entry[w_grant_idx].data;
            l2req_packet.mask    = r_entry[w_grant_idx].mask;
        end
    end

    // Rollback and forwarding results line up with the D$ hit/miss response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rollback_o       <= 1'b0;
            data_o           <= '0;
            mask_o           <= '0;
            resume_strands_o <= '0;
            sync_result_o    <= 1'b0;
        end else begin
            rollback_o       <= store_en && !w_store_ok;
            data_o           <= w_load_hit ? r_entry[store_strand].data : '0;
            mask_o           <= w_load_hit ? r_entry[store_strand].mask : '0;
            resume_strands_o <= w_ack_hit ? (STRANDS_PER_CORE'(1) << l2rsp_packet.strand) : '0;
            if (w_ack_hit && r_entry[l2rsp_packet.strand].sync)
                sync_result_o <= l2rsp_packet.status;
        end
    end

    ack_targets_issued_entry: assert property (
        @(posedge clk) disable iff (reset) w_ack |-> (r_state[l2rsp_packet.strand] == SB_ISSUED));

endmodule
